muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter BYPASS_TRIVIAL, default 1: when 1, divide-by-zero and signed-overflow divides SHALL complete without iterating.
REQ-002 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  issue request, sampled only in IDLE.
REQ-005 SELECT  input  5  op code, using the ALU SELECT encoding: 01011 MUL, 01100 MULH, 01101 MULHSU, 01110 MULHU, 01111 DIV, 10000 DIVU, 10001 REM, 10010 REMU.
REQ-006 DATA1  input  32  rs1 operand (multiplicand / dividend).
REQ-007 DATA2  input  32  rs2 operand (multiplier / divisor).
REQ-008 TAG_IN  input  5  destination register tag captured at issue.
REQ-009 FLUSH  input  1  abort the in-flight op.
REQ-010 BUSY  output  1  high in any state except IDLE; used as the pipeline stall.
REQ-011 RESULT_VALID  output  1  one-cycle completion strobe.
REQ-012 RESULT  output  32  result of the completed op.
REQ-013 TAG_OUT  output  5  tag of the completed op.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-015 IDLE SHALL go to CALC on an edge with START=1, FLUSH=0 and SELECT in 01011..10010; other SELECT values SHALL be ignored, leaving the FSM in IDLE.
REQ-016 At issue the block SHALL latch DATA1, DATA2, SELECT and TAG_IN; later input changes SHALL have no effect on the in-flight op.
REQ-017 START SHALL be ignored in CALC and DONE.
REQ-018 CALC SHALL run for exactly 32 cycles using a 5-bit iteration counter, one radix-2 step per cycle (shift-add multiply; restoring divide on magnitudes).
REQ-019 After the 32nd CALC cycle the FSM SHALL enter DONE, and SHALL return to IDLE on the following edge.
REQ-020 Latency: START sampled at edge E0 -> CALC from E0 to E32 -> DONE between E32 and E33 -> IDLE after E33.
REQ-021 RESULT_VALID SHALL equal (state==DONE && FLUSH==0).
REQ-022 RESULT and TAG_OUT SHALL be registered on entry to DONE and SHALL hold until the next DONE.
REQ-023 Multiply results:
- MUL: low 32 bits of the 64-bit product.
- MULH: high 32 bits, signed x signed.
- MULHSU: high 32 bits, signed DATA1 x unsigned DATA2.
- MULHU: high 32 bits, unsigned x unsigned.
REQ-024 Signed divide:
- DIV: quotient truncated toward zero.
- REM: remainder takes the sign of the dividend.
- Sign correction: two's-complement negation of the magnitude result.
REQ-025 Divide by zero:
- DIV and DIVU SHALL return 0xFFFFFFFF.
- REM and REMU SHALL return DATA1.
REQ-026 Signed overflow (DIV or REM with DATA1=0x80000000, DATA2=0xFFFFFFFF):
- DIV SHALL return 0x80000000.
- REM SHALL return 0.
REQ-027 With BYPASS_TRIVIAL=1, the REQ-025 and REQ-026 cases SHALL go IDLE -> DONE at E0 (RESULT_VALID between E0 and E1); with BYPASS_TRIVIAL=0 they SHALL take the full 32 CALC cycles and return identical values.
REQ-028 FLUSH=1 in CALC or DONE SHALL force IDLE on the next edge, with no RESULT_VALID pulse; a flush in CALC SHALL leave RESULT and TAG_OUT unchanged.
REQ-029 FLUSH=1 with START=1 in IDLE SHALL not issue.

Reset
REQ-030 RESET=0 SHALL immediately, without waiting for CLK, force:
- state IDLE and counter 0;
- BUSY=0, RESULT_VALID=0;
- RESULT=0x00000000, TAG_OUT=0;
- all latched operands to 0.
REQ-031 Reset asserted during CALC or DONE SHALL discard the op with no RESULT_VALID; the first START after RESET returns high SHALL be accepted normally.

Verification
REQ-032 MUL 20 x 10, TAG_IN=5 -> BUSY high for 33 cycles, one RESULT_VALID with RESULT=200 and TAG_OUT=5.
REQ-033 DATA1=0xFFFFFFFF, DATA2=2 -> MULH 0xFFFFFFFF, MULHSU 0xFFFFFFFF, MULHU 0x00000001, MUL 0xFFFFFFFE.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 20/10 -> 2; REMU 20/10 -> 0.
REQ-035 Trivial cases with BYPASS_TRIVIAL=1: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each strobing one cycle after issue; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-036 FLUSH in CALC cycle 10 -> IDLE next edge, no strobe, RESULT unchanged; RESET low in CALC cycle 20 -> all outputs 0 at once; START during BUSY, or with SELECT=00001 -> ignored.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle over 32 cycles.
// Operands are latched at issue; RESULT/TAG_OUT are registered on entry to DONE.
module muldiv_sequencer #(
    parameter bit BYPASS_TRIVIAL = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [4:0]  SELECT,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [4:0]  TAG_IN,
    input  logic        FLUSH,
    output logic        BUSY,
    output logic        RESULT_VALID,
    output logic [31:0] RESULT,
    output logic [4:0]  TAG_OUT
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [4:0] SEL_MUL    = 5'b01011;
    localparam logic [4:0] SEL_MULH   = 5'b01100;
    localparam logic [4:0] SEL_MULHSU = 5'b01101;
    localparam logic [4:0] SEL_DIV    = 5'b01111;
    localparam logic [4:0] SEL_DIVU   = 5'b10000;
    localparam logic [4:0] SEL_REM    = 5'b10001;
    localparam logic [4:0] SEL_REMU   = 5'b10010;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  sel_q, sel_d, tag_q, tag_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  tag_out_q, tag_out_d;

    logic [31:0] mag_a, mag_b, diff;
    logic [32:0] sum;
    logic [63:0] acc_step;

    function automatic logic sel_valid(input logic [4:0] sel);
        return (sel >= SEL_MUL) && (sel <= SEL_REMU);
    endfunction

    function automatic logic is_div(input logic [4:0] sel);
        return sel >= SEL_DIV;
    endfunction

    function automatic logic a_signed(input logic [4:0] sel);
        return (sel == SEL_MUL) || (sel == SEL_MULH) || (sel == SEL_MULHSU) ||
               (sel == SEL_DIV) || (sel == SEL_REM);
    endfunction

    function automatic logic b_signed(input logic [4:0] sel);
        return (sel == SEL_MUL) || (sel == SEL_MULH) || (sel == SEL_DIV) || (sel == SEL_REM);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_op);
        return (signed_op && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_trivial(input logic [4:0] sel, input logic [31:0] a,
                                        input logic [31:0] b);
        return is_div(sel) && ((b == 32'd0) ||
               (((sel == SEL_DIV) || (sel == SEL_REM)) &&
                (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    function automatic logic [31:0] trivial_result(input logic [4:0] sel, input logic [31:0] a,
                                                   input logic [31:0] b);
        if (b == 32'd0)
            return ((sel == SEL_DIV) || (sel == SEL_DIVU)) ? 32'hFFFF_FFFF : a;
        return (sel == SEL_DIV) ? 32'h8000_0000 : 32'd0;
    endfunction

    // Sign-correct the magnitude result held in acc ({remainder, quotient} for divides).
    function automatic logic [31:0] finalize(input logic [4:0] sel, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] p;
        if (!is_div(sel)) begin
            p = ((a_signed(sel) & a[31]) ^ (b_signed(sel) & b[31])) ? (~acc + 64'd1) : acc;
            return (sel == SEL_MUL) ? p[31:0] : p[63:32];
        end
        if (is_trivial(sel, a, b)) return trivial_result(sel, a, b);
        case (sel)
            SEL_DIV:  return (a[31] ^ b[31]) ? (~acc[31:0] + 32'd1) : acc[31:0];
            SEL_DIVU: return acc[31:0];
            SEL_REM:  return a[31] ? (~acc[63:32] + 32'd1) : acc[63:32];
            default:  return acc[63:32];
        endcase
    endfunction

    always_comb begin
        mag_a    = abs32(a_q, a_signed(sel_q));
        mag_b    = abs32(b_q, b_signed(sel_q));
        sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a} : 33'd0);
        diff     = acc_q[62:31] - mag_b;
        acc_step = {sum, acc_q[31:1]};
        if (is_div(sel_q)) begin
            // Restoring step: shift remainder left by one dividend bit, subtract if it fits.
            if (acc_q[63:31] >= {1'b0, mag_b})
                acc_step = {diff, acc_q[30:0], 1'b1};
            else
                acc_step = {acc_q[62:0], 1'b0};
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        tag_d     = tag_q;
        acc_d     = acc_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        case (state_q)
            IDLE: begin
                if (START && !FLUSH && sel_valid(SELECT)) begin
                    a_d   = DATA1;
                    b_d   = DATA2;
                    sel_d = SELECT;
                    tag_d = TAG_IN;
                    cnt_d = 5'd0;
                    acc_d = is_div(SELECT) ? {32'd0, abs32(DATA1, a_signed(SELECT))}
                                           : {32'd0, abs32(DATA2, b_signed(SELECT))};
                    if (BYPASS_TRIVIAL && is_trivial(SELECT, DATA1, DATA2)) begin
                        state_d   = DONE;
                        result_d  = trivial_result(SELECT, DATA1, DATA2);
                        tag_out_d = TAG_IN;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (FLUSH) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d   = DONE;
                        result_d  = finalize(sel_q, a_q, b_q, acc_step);
                        tag_out_d = tag_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sel_q     <= 5'd0;
            tag_q     <= 5'd0;
            acc_q     <= 64'd0;
            result_q  <= 32'd0;
            tag_out_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            tag_q     <= tag_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign BUSY         = (state_q != IDLE);
    assign RESULT_VALID = (state_q == DONE) && !FLUSH;
    assign RESULT       = result_q;
    assign TAG_OUT      = tag_out_q;
endmodule
